// File: rtl/miner_work_scheduler.sv
// Nonce-range work scheduler: latches a job, streams nonces to a pipelined hash core and reports
// the first golden nonce or range exhaustion. Optional preemption via MINER_SCHED_PREEMPT_EN.
module miner_work_scheduler #(
    parameter int unsigned LATENCY    = 64,
    parameter int unsigned NONCE_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  work_nonce_lo,
    input  logic [31:0]  work_nonce_hi,
    output logic [255:0] core_midstate,
    output logic [95:0]  core_data,
    output logic [31:0]  core_nonce,
    output logic         core_issue,
    input  logic         core_hit,
    input  logic [31:0]  core_hit_nonce,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_nonce,
    output logic         res_found,
    output logic         busy
);

    localparam logic [7:0]  LatCnt = 8'(LATENCY);
    localparam logic [32:0] Step33 = 33'(NONCE_STEP);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StFlush, StReport} state_e;

    state_e         state_q, state_d;
    logic [255:0]   midstate_q, midstate_d;
    logic [95:0]    data_q, data_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    hi_q, hi_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [31:0]    res_nonce_q, res_nonce_d;
    logic           res_found_q, res_found_d;

    logic           accept;
    logic           range_empty;
    logic           last_issue;
    logic [32:0]    nonce_next33;

`ifdef MINER_SCHED_PREEMPT_EN
    assign work_ready = (state_q == StIdle) || (state_q == StRun) || (state_q == StDrain);
`else
    assign work_ready = (state_q == StIdle);
`endif

    assign accept      = work_valid && work_ready;
    assign range_empty = work_nonce_lo > work_nonce_hi;

    // 33-bit sum so a range ending at 0xFFFFFFFF terminates instead of wrapping to 0
    assign nonce_next33 = {1'b0, nonce_q} + Step33;
    assign last_issue   = (nonce_q == hi_q) || (nonce_next33 > {1'b0, hi_q});

    always_comb begin
        state_d     = state_q;
        midstate_d  = midstate_q;
        data_d      = data_q;
        nonce_d     = nonce_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        res_nonce_d = res_nonce_q;
        res_found_d = res_found_q;
        core_issue  = 1'b0;
        res_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StRun: begin
                core_issue = 1'b1;
                if (core_hit) begin
                    res_nonce_d = core_hit_nonce;
                    res_found_d = 1'b1;
                    state_d     = StReport;
                end else if (last_issue) begin
                    res_nonce_d = nonce_q;
                    res_found_d = 1'b0;
                    cnt_d       = LatCnt;
                    state_d     = StDrain;
                end else begin
                    nonce_d = nonce_next33[31:0];
                end
            end
            StDrain: begin
                cnt_d = cnt_q - 8'd1;
                if (core_hit) begin
                    res_nonce_d = core_hit_nonce;
                    res_found_d = 1'b1;
                    state_d     = StReport;
                end else if (cnt_q == 8'd1) begin
                    state_d = StReport;
                end
            end
            StFlush: begin
                // Results of the aborted job still emerge from the core here; drop them
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StRun;
                end
            end
            StReport: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A new job overrides whatever the current state decided this cycle
        if (accept) begin
            midstate_d = work_midstate;
            data_d     = work_data;
            nonce_d    = work_nonce_lo;
            hi_d       = work_nonce_hi;
            if (range_empty) begin
                res_nonce_d = work_nonce_lo;
                res_found_d = 1'b0;
                state_d     = StReport;
            end else if (state_q == StIdle) begin
                state_d = StRun;
            end else begin
                cnt_d   = LatCnt;
                state_d = StFlush;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            midstate_q  <= '0;
            data_q      <= '0;
            nonce_q     <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            res_nonce_q <= '0;
            res_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            midstate_q  <= midstate_d;
            data_q      <= data_d;
            nonce_q     <= nonce_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            res_nonce_q <= res_nonce_d;
            res_found_q <= res_found_d;
        end
    end

    assign core_midstate = midstate_q;
    assign core_data     = data_q;
    assign core_nonce    = nonce_q;
    assign res_nonce     = res_nonce_q;
    assign res_found     = res_found_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_miner_work_scheduler.sv
// Self-checking bench for miner_work_scheduler: directed vector table, hand sequences for reset
// and preemption, and random jobs checked against a range/latency model.
module tb_miner_work_scheduler;

    localparam int unsigned LAT = 4;

    logic         clk;
    logic         rst_n;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [31:0]  work_nonce_lo;
    logic [31:0]  work_nonce_hi;
    logic [255:0] core_midstate;
    logic [95:0]  core_data;
    logic [31:0]  core_nonce;
    logic         core_issue;
    logic         core_hit;
    logic [31:0]  core_hit_nonce;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;
    logic         res_found;
    logic         busy;

    int total;
    int bad;

    miner_work_scheduler #(
        .LATENCY    (LAT),
        .NONCE_STEP (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .work_valid     (work_valid),
        .work_ready     (work_ready),
        .work_midstate  (work_midstate),
        .work_data      (work_data),
        .work_nonce_lo  (work_nonce_lo),
        .work_nonce_hi  (work_nonce_hi),
        .core_midstate  (core_midstate),
        .core_data      (core_data),
        .core_nonce     (core_nonce),
        .core_issue     (core_issue),
        .core_hit       (core_hit),
        .core_hit_nonce (core_hit_nonce),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_nonce      (res_nonce),
        .res_found      (res_found),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          hit_at;
        logic [31:0] hn;
        int          issues;
        int          rescyc;
        logic        found;
        logic [31:0] nonce;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends at posedge+1 with the scheduler idle
    task automatic run_job(input logic [31:0] lo, input logic [31:0] hi, input int hit_at,
                           input logic [31:0] hn, input int exp_issues, input int exp_rescyc,
                           input logic exp_found, input logic [31:0] exp_nonce, input int hold,
                           input bit offer);
        logic [255:0] ms;
        logic [95:0]  dt;
        int           cyc;
        bit           seen;
        ms = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        dt = {$urandom, $urandom, $urandom};
        chk("idle_ready", {63'd0, work_ready}, 64'd1);
        work_valid    = 1'b1;
        work_nonce_lo = lo;
        work_nonce_hi = hi;
        work_midstate = ms;
        work_data     = dt;
        tick();
        work_valid    = offer;
        work_nonce_lo = lo + 32'h1000;
        work_midstate = ~ms;
        work_data     = ~dt;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc <= exp_rescyc + 8) begin
            core_hit       = (cyc == hit_at);
            core_hit_nonce = (cyc == hit_at) ? hn : $urandom;
            @(negedge clk);
            if (res_valid) begin
                seen       = 1;
                work_valid = 1'b0;
                chk("res_cycle", 64'(cyc), 64'(exp_rescyc));
            end else begin
                chk("issue", {63'd0, core_issue}, {63'd0, cyc < exp_issues});
                if (core_issue) chk("nonce", {32'd0, core_nonce}, {32'd0, lo + 32'(cyc)});
                chk("busy", {63'd0, busy}, 64'd1);
`ifndef MINER_SCHED_PREEMPT_EN
                chk("ready_in_job", {63'd0, work_ready}, 64'd0);
`endif
            end
            tick();
            cyc++;
        end
        core_hit = 1'b0;
        if (!seen) begin
            chk("res_timeout", 64'd0, 64'd1);
            work_valid = 1'b0;
        end
        @(negedge clk);
        chk("res_found", {63'd0, res_found}, {63'd0, exp_found});
        chk("res_nonce", {32'd0, res_nonce}, {32'd0, exp_nonce});
        chk("midstate_held", {63'd0, core_midstate === ms}, 64'd1);
        chk("data_held", {63'd0, core_data === dt}, 64'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            core_hit       = $urandom_range(0, 1) == 1;
            core_hit_nonce = $urandom;
            @(negedge clk);
            chk("hold_valid", {63'd0, res_valid}, 64'd1);
            chk("hold_nonce", {32'd0, res_nonce}, {32'd0, exp_nonce});
            chk("hold_found", {63'd0, res_found}, {63'd0, exp_found});
        end
        tick();
        core_hit  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        chk("post_ready", {63'd0, work_ready}, 64'd1);
        chk("post_busy", {63'd0, busy}, 64'd0);
        chk("post_valid", {63'd0, res_valid}, 64'd0);
        tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, work_ready}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_issue"}, {63'd0, core_issue}, 64'd0);
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_buses"}, {63'd0, (core_nonce | res_nonce) == 32'd0 && core_midstate == '0
                                      && core_data == '0 && !res_found}, 64'd1);
    endtask

    initial begin
        int          n;
        int          hit_at;
        int          issues;
        int          rescyc;
        logic        found;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] hn;
        logic [31:0] enonce;
        longint      hi64;
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        work_valid     = 1'b0;
        work_midstate  = '0;
        work_data      = '0;
        work_nonce_lo  = '0;
        work_nonce_hi  = '0;
        core_hit       = 1'b0;
        core_hit_nonce = '0;
        res_ready      = 1'b0;

        vecs[0] = '{32'h10, 32'h13, -1, 32'h0, 4, 8, 1'b0, 32'h13, 2};
        vecs[1] = '{32'h0, 32'hFF, 46, 32'h2A, 47, 47, 1'b1, 32'h2A, 3};
        vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, 32'h0, 2, 6, 1'b0, 32'hFFFF_FFFF, 1};
        vecs[3] = '{32'h5, 32'h4, -1, 32'h0, 0, 0, 1'b0, 32'h5, 10};
        vecs[4] = '{32'h20, 32'h22, 4, 32'h21, 3, 5, 1'b1, 32'h21, 1};
        vecs[5] = '{32'h1, 32'h3, 2, 32'h3, 3, 3, 1'b1, 32'h3, 1};
        vecs[6] = '{32'h7, 32'h7, 5, 32'h99, 1, 5, 1'b0, 32'h7, 1};
        vecs[7] = '{32'h30, 32'h30, 4, 32'hAB, 1, 5, 1'b1, 32'hAB, 1};

        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].lo, vecs[i].hi, vecs[i].hit_at, vecs[i].hn, vecs[i].issues,
                    vecs[i].rescyc, vecs[i].found, vecs[i].nonce, vecs[i].hold, 1'b0);
        end

        // Reset mid-run at nonce 0x50
        work_valid    = 1'b1;
        work_nonce_lo = 32'h40;
        work_nonce_hi = 32'h1000;
        work_midstate = {8{32'hA5A5_5A5A}};
        work_data     = {3{32'h1234_5678}};
        tick();
        work_valid = 1'b0;
        repeat (16) tick();
        chk("pre_reset_nonce", {32'd0, core_nonce}, 64'h50);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("no_stale_result", {62'd0, res_valid, busy}, 64'd0);
        end
        tick();
        run_job(32'h60, 32'h62, -1, 32'h0, 3, 7, 1'b0, 32'h62, 0, 1'b0);

`ifdef MINER_SCHED_PREEMPT_EN
        work_valid    = 1'b1;
        work_nonce_lo = 32'h0;
        work_nonce_hi = 32'hFFFF;
        tick();
        work_valid = 1'b0;
        repeat (5) tick();
        work_valid    = 1'b1;
        work_nonce_lo = 32'h100;
        work_nonce_hi = 32'h103;
        @(negedge clk);
        chk("preempt_ready", {63'd0, work_ready}, 64'd1);
        tick();
        work_valid = 1'b0;
        for (int f = 0; f < int'(LAT); f++) begin
            core_hit       = (f == 1);
            core_hit_nonce = 32'hDEAD;
            @(negedge clk);
            chk("flush_issue", {63'd0, core_issue}, 64'd0);
            chk("flush_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        core_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("resume_issue", {63'd0, core_issue}, 64'd1);
            chk("resume_nonce", {32'd0, core_nonce}, 64'h100 + 64'(i));
            tick();
        end
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk("preempt_res", {31'd0, res_valid, res_found, res_nonce}, {31'd0, 2'b10, 32'h103});
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
`else
        // A competing job stays offered for the whole run and must not be taken
        run_job(32'h200, 32'h209, -1, 32'h0, 10, 14, 1'b0, 32'h209, 1, 1'b1);
`endif

        for (int r = 0; r < 40; r++) begin
            lo = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom | 32'h10);
            if ($urandom_range(0, 7) == 0) begin
                hi = lo - 32'd1 - $urandom_range(0, 3);
            end else begin
                hi64 = longint'(lo) + longint'($urandom_range(0, 30));
                hi   = (hi64 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : hi64[31:0];
            end
            n      = (hi >= lo) ? int'(hi - lo) + 1 : 0;
            hit_at = $urandom_range(0, 1) == 1 ? int'($urandom_range(0, n + LAT + 2)) : -1;
            hn     = $urandom;
            if (n == 0) begin
                issues = 0;
                rescyc = 0;
                found  = 1'b0;
                enonce = lo;
            end else if (hit_at >= 0 && hit_at < n + int'(LAT)) begin
                issues = (hit_at + 1 < n) ? hit_at + 1 : n;
                rescyc = hit_at + 1;
                found  = 1'b1;
                enonce = hn;
            end else begin
                issues = n;
                rescyc = n + int'(LAT);
                found  = 1'b0;
                enonce = lo + 32'(n - 1);
            end
            run_job(lo, hi, hit_at, hn, issues, rescyc, found, enonce,
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/miner_work_scheduler.md
MINER_WORK_SCHEDULER -- requirements
Module: miner_work_scheduler

Interface
REQ-001 Parameter LATENCY, default 64: cycles from core_issue of a nonce to its core_hit; range 1..255.
REQ-002 Parameter NONCE_STEP, default 1: nonce increment per issue cycle; power of two, 1..2^31.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 work_valid  in  1  new job offered.
REQ-006 work_ready  out  1  scheduler accepts job.
REQ-007 work_midstate  in  256  SHA-256 midstate of job.
REQ-008 work_data  in  96  header tail of job.
REQ-009 work_nonce_lo  in  32  first nonce, inclusive.
REQ-010 work_nonce_hi  in  32  last nonce, inclusive.
REQ-011 core_midstate  out  256, core_data  out  96  latched job, held stable for whole job.
REQ-012 core_nonce  out  32, core_issue  out  1  nonce presented to hash core, valid when core_issue=1.
REQ-013 core_hit  in  1, core_hit_nonce  in  32  core reports golden nonce.
REQ-014 res_valid  out  1, res_ready  in  1  result handshake.
REQ-015 res_nonce  out  32, res_found  out  1  golden nonce (found=1) or last issued nonce (found=0, range exhausted).
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 States IDLE, RUN, DRAIN, FLUSH, REPORT; one-hot or encoded, implementation choice.
REQ-018 IDLE: work_ready=1; on work_valid&&work_ready latch midstate/data/lo/hi, next state RUN with core_nonce=lo; if lo>hi go REPORT with res_found=0, res_nonce=lo, nothing issued.
REQ-019 RUN: core_issue=1 every cycle; core_nonce advances by NONCE_STEP per cycle, no idle bubbles.
REQ-020 RUN ends after the cycle issuing nonce n where n==hi or n+NONCE_STEP>hi (33-bit compare; no 32-bit wrap, 0xFFFFFFFF issued once and never followed by 0); next state DRAIN, counter=LATENCY.
REQ-021 DRAIN: core_issue=0; counter decrements per cycle; at 0 go REPORT, res_found=0, res_nonce=last issued nonce.
REQ-022 core_hit in RUN or DRAIN: capture core_hit_nonce, core_issue=0 from next cycle, go REPORT with res_found=1; hit on same cycle as RUN→DRAIN transition takes priority (found=1).
REQ-023 core_hit in IDLE, FLUSH or REPORT ignored; only the first hit per job reported.
REQ-024 REPORT: res_valid=1, res_nonce/res_found stable until res_valid&&res_ready; then IDLE (work_ready=1 next cycle).
REQ-025 Job accept to first core_issue: exactly 1 cycle.

Reset
REQ-026 rst_n low: state IDLE immediately; work_ready=1 after reset, all other outputs 0 (core_* buses 0, busy=0, res_valid=0).
REQ-027 Reset mid-job discards job and any pending result; no res_valid after release until a new job completes.

Configuration
REQ-028 Macro MINER_SCHED_PREEMPT_EN defined: work_ready=1 also in RUN and DRAIN; accepting a job aborts current one with no result, latches new job, enters FLUSH for LATENCY cycles (core_issue=0, hits ignored), then RUN at new lo.
REQ-029 Macro undefined: work_ready=1 only in IDLE; FLUSH unreachable; offered jobs wait.

Verification
REQ-030 LATENCY=4, lo=0x10, hi=0x13, core never hits -> core_nonce 0x10..0x13 on 4 consecutive cycles, 4 DRAIN cycles, res_valid with res_found=0, res_nonce=0x13.
REQ-031 lo=0, hi=0xFF, core_hit with core_hit_nonce=0x2A during RUN -> core_issue drops next cycle, res_found=1, res_nonce=0x2A; second hit ignored.
REQ-032 lo=0xFFFFFFFE, hi=0xFFFFFFFF, NONCE_STEP=1 -> exactly two issues (…FE, …FF), no wrap to 0, res_found=0, res_nonce=0xFFFFFFFF.
REQ-033 lo=5, hi=4 -> no core_issue, res_valid next cycle with res_found=0, res_nonce=5; res_ready held low 10 cycles -> outputs stable.
REQ-034 rst_n pulsed low during RUN at nonce 0x50 -> outputs zero asynchronously, busy=0, no result; next job runs from its lo.
REQ-035 With MINER_SCHED_PREEMPT_EN, second job (lo=0x100) accepted during RUN, stale hit injected during FLUSH -> hit ignored, RUN resumes at 0x100 after LATENCY cycles; without macro, work_ready=0 throughout RUN.
